// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state type and latency/legality helpers for the ALU sequencer.
`timescale 1ns/1ps
package alu_seq_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_ADD = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_REM = 4'b1010;

  // Wait counter width; MUL_CYCLES/DIV_CYCLES must fit in it.
  localparam int SEQ_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_REM);
  endfunction

  function automatic logic [SEQ_CNT_W-1:0] op_latency(
    input logic [3:0]           op,
    input logic [SEQ_CNT_W-1:0] mul_n,
    input logic [SEQ_CNT_W-1:0] div_n
  );
    if (op == OP_MUL)
      return mul_n;
    else if (op == OP_DIV || op == OP_REM)
      return div_n;
    else
      return SEQ_CNT_W'(1);
  endfunction

endpackage

// File: rtl/alu_wait_timer.sv
// Loadable down-counter; done is high while the count sits at 1 (last wait cycle).
`timescale 1ns/1ps
module alu_wait_timer
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - CNT_W'(1);
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end controller for the 16-bit ALU: one request in flight, fixed per-opcode wait, registered response.
// Optional busy-cycle counter output enabled by defining ALU_SEQ_BUSY_CNT_EN.
`timescale 1ns/1ps
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 17,
  parameter int DIV_CYCLES = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_select,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_op,
  output logic             rsp_err
`ifdef ALU_SEQ_BUSY_CNT_EN
  ,
  output logic [31:0]      busy_cycles
`endif
);

  localparam logic [SEQ_CNT_W-1:0] MUL_N = SEQ_CNT_W'(MUL_CYCLES);
  localparam logic [SEQ_CNT_W-1:0] DIV_N = SEQ_CNT_W'(DIV_CYCLES);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic             timer_done;

  // Operands stay on the ALU inputs from ISSUE until the next acceptance.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_select = op_q;

  alu_wait_timer #(
    .CNT_W(SEQ_CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ISSUE),
    .en      (state == WAIT),
    .load_val(op_latency(op_q, MUL_N, DIV_N)),
    .done    (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q       <= req_a;
            b_q       <= req_b;
            op_q      <= req_op;
            req_ready <= 1'b0;
            // Illegal opcodes never kick the multiplier/divider.
            alu_start <= op_legal(req_op);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_legal(op_q)) begin
            state <= WAIT;
          end else begin
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
            rsp_op     <= op_q;
            rsp_err    <= 1'b1;
            state      <= DONE;
          end
        end
        WAIT: begin
          if (timer_done) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_op     <= op_q;
            rsp_err    <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_BUSY_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_cycles <= '0;
    else if (state != IDLE && busy_cycles != 32'hFFFF_FFFF)
      busy_cycles <= busy_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU and reference model.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int WIDTH      = 16;
  localparam int MUL_CYCLES = 17;
  localparam int DIV_CYCLES = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_op = '0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_select;
  logic        alu_start;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_op;
  logic        rsp_err;
`ifdef ALU_SEQ_BUSY_CNT_EN
  logic [31:0] busy_cycles;
`endif

  alu_op_sequencer #(
    .WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_start(alu_start), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err)
`ifdef ALU_SEQ_BUSY_CNT_EN
    , .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] res;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_hs = -100;
  int   starts = 0;
  int   k = 0;
  bit   rdy_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a ^ b;
      4'd3:  return ~a;
      4'd4:  return a << b[3:0];
      4'd5:  return a >> b[3:0];
      4'd6:  return a + b;
      4'd7:  return a - b;
      4'd8:  return a * b;
      4'd9:  return (b == 16'd0) ? 16'hFFFF : a / b;
      4'd10: return (b == 16'd0) ? a : a % b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int exp_latency(input logic [3:0] op);
    if (op > 4'd10) return 2;
    if (op == 4'd8) return 2 + MUL_CYCLES;
    if (op == 4'd9 || op == 4'd10) return 2 + DIV_CYCLES;
    return 3;
  endfunction

  // Behavioural ALU: iterative ops show a corrupted value until their iteration count has elapsed.
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else if (alu_start) k <= 1;
    else if (k > 0 && k < 1000) k <= k + 1;
  end

  always_comb begin
    alu_result = ref_alu(alu_a, alu_b, alu_select);
    if ((alu_select == 4'd8 && k < MUL_CYCLES) ||
        ((alu_select == 4'd9 || alu_select == 4'd10) && k < DIV_CYCLES))
      alu_result = alu_result ^ 16'h5A5A;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: latency, handshake data, stall stability and operand hold.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] prev_res;
  logic [3:0]  prev_op;
  logic        prev_err;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      starts = 0;
    end else begin
      if (alu_start) starts++;
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
        chk("stall_hold", {11'd0, rsp_err, rsp_op, rsp_result}, {11'd0, prev_err, prev_op, prev_res});
      end
      if (!req_ready && q.size() > 0)
        chk("alu_operands", {alu_select, alu_a, alu_b}, {q[0].op, q[0].a, q[0].b});
      if (rsp_valid) begin
        chk("req_ready_low", {31'd0, req_ready}, 32'd0);
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got result %0h with empty scoreboard", rsp_result);
        end else begin
          if (!prev_valid) begin
            chk("latency", cyc, q[0].due);
            chk("start_pulses", starts, q[0].err ? 0 : 1);
            starts = 0;
          end
          if (rsp_ready) begin
            chk("rsp_result", rsp_result, q[0].res);
            chk("rsp_op", rsp_op, q[0].op);
            chk("rsp_err", rsp_err, q[0].err);
            void'(q.pop_front());
            last_hs = cyc;
          end
        end
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      prev_res   = rsp_result;
      prev_op    = rsp_op;
      prev_err   = rsp_err;
    end
  end

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1 rsp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                      output int acc);
    exp_t e;
    int   w;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready stuck at 0, expected 1 within 500 cycles");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    e.a = a; e.b = b; e.op = op;
    e.err = (op > 4'd10);
    e.res = e.err ? 16'h0000 : ref_alu(a, b, op);
    e.due = cyc + exp_latency(op);
    q.push_back(e);
    acc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() > 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int acc2;
    logic [15:0] ra;
    logic [15:0] rb;
    #12;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_outputs", {alu_start, rsp_valid, rsp_err, rsp_op, rsp_result, alu_select},
        32'd0);
    chk("reset_operands", {alu_a, alu_b}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    send(16'h00F0, 16'h0FF0, 4'b0000, acc); drain();
    send(16'd3, 16'd5, 4'b1000, acc);         drain();
    send(16'd100, 16'd7, 4'b1001, acc);       drain();
    send(16'd100, 16'd7, 4'b1010, acc);       drain();
    send(16'h1234, 16'h5678, 4'b1111, acc);   drain();
    send(16'd9, 16'd0, 4'b1001, acc);         drain();

    // Held-off response with a second request queued behind it.
    rsp_ready = 1'b0;
    send(16'hFFFF, 16'h0001, 4'b0110, acc);
    fork
      begin
        repeat (13) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
      send(16'hA5A5, 16'h0F0F, 4'b0010, acc2);
    join
    chk("queued_accept_cycle", acc2, last_hs + 1);
    drain();

    // Reset in the middle of a multiply.
    send(16'd11, 16'd13, 4'b1000, acc);
    while (cyc < acc + 9) begin
      @(posedge clk);
      #1;
    end
    #1;
    q.delete();
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_alu_start", {31'd0, alu_start}, 32'd0);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'd11, 16'd13, 4'b1000, acc); drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      send(ra, rb, 4'($urandom_range(0, 15)), acc);
    end
    @(posedge clk);
    rdy_rand = 1'b0;
    #2 rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
